// File: rtl/counter_seq_ctrl_if.sv
// Command/response bus between counter_seq_ctrl and a 4-bit synchronous up/down counter.
// master = controller side, slave = counter side.
interface counter_seq_ctrl_if;
  logic       load;
  logic       en;
  logic       dn;
  logic [3:0] d;
  logic [3:0] q_in;
  logic       co_in;

  modport master (
    output load, en, dn, d,
    input  q_in, co_in
  );

  modport slave (
    input  load, en, dn, d,
    output q_in, co_in
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencer for a 4-bit up/down counter: preset load, N divided-rate count pulses, wrap counting.
// Optional q_in reference check is built only when CTRL_CHECK_EN is defined.
module counter_seq_ctrl #(
  parameter int unsigned DIV    = 4,
  parameter int unsigned STEP_W = 8
) (
  input  logic                  clk,
  input  logic                  mr,
  input  logic                  start,
  input  logic                  mode,
  input  logic [3:0]            preset,
  input  logic [STEP_W-1:0]     steps,
  counter_seq_ctrl_if.master    cbus,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            wraps,
  output logic                  mismatch
);

  localparam logic [7:0]        PrescMax = 8'(DIV - 1);
  localparam logic [STEP_W-1:0] StepOne  = STEP_W'(1);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [3:0]          preset_q, preset_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [7:0]          presc_q, presc_d;
  logic [3:0]          wraps_q, wraps_d;
  logic                co_prev_q;

  logic load_s, en_s, busy_s, done_s, start_acc;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    preset_d  = preset_q;
    steps_d   = steps_q;
    presc_d   = presc_q;
    wraps_d   = wraps_q;
    load_s    = 1'b0;
    en_s      = 1'b0;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    start_acc = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          start_acc = 1'b1;
          mode_d    = mode;
          preset_d  = preset;
          steps_d   = steps;
          wraps_d   = 4'd0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        load_s  = 1'b1;
        busy_s  = 1'b1;
        presc_d = 8'd0;
        state_d = (steps_q != '0) ? StRun : StDrain;
      end
      StRun: begin
        busy_s  = 1'b1;
        // en fires on prescaler phase 0, so the first RUN cycle always pulses
        en_s    = (presc_q == 8'd0);
        presc_d = (presc_q == PrescMax) ? 8'd0 : presc_q + 8'd1;
        if (en_s) begin
          steps_d = steps_q - StepOne;
          if (steps_q == StepOne) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        busy_s  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        done_s  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (busy_s && cbus.co_in && !co_prev_q && (wraps_q != 4'hF)) begin
      wraps_d = wraps_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      state_q   <= StIdle;
      mode_q    <= 1'b0;
      preset_q  <= 4'd0;
      steps_q   <= '0;
      presc_q   <= 8'd0;
      wraps_q   <= 4'd0;
      co_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      preset_q  <= preset_d;
      steps_q   <= steps_d;
      presc_q   <= presc_d;
      wraps_q   <= wraps_d;
      co_prev_q <= cbus.co_in;
    end
  end

  assign cbus.load = load_s;
  assign cbus.en   = en_s;
  assign cbus.dn   = mode_q;
  assign cbus.d    = preset_q;
  assign busy      = busy_s;
  assign done      = done_s;
  assign wraps     = wraps_q;

`ifdef CTRL_CHECK_EN
  logic [3:0] exp_q, exp_d;
  logic       chk_q;
  logic       mismatch_q, mismatch_d;

  always_comb begin
    exp_d      = exp_q;
    mismatch_d = mismatch_q;
    if (start_acc) begin
      mismatch_d = 1'b0;
    end else if (chk_q && (cbus.q_in != exp_q)) begin
      mismatch_d = 1'b1;
    end
    if (load_s) begin
      exp_d = preset_q;
    end else if (en_s) begin
      exp_d = mode_q ? exp_q - 4'd1 : exp_q + 4'd1;
    end
  end

  // chk_q marks the cycle where the counter has absorbed the last load/en
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      exp_q      <= 4'd0;
      chk_q      <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      exp_q      <= exp_d;
      chk_q      <= load_s | en_s;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  logic unused_q_in;
  logic unused_start_acc;
  assign unused_q_in      = ^cbus.q_in;
  assign unused_start_acc = start_acc;
  assign mismatch         = 1'b0;
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl: two instances (DIV=1, DIV=3) each driving a
// behavioural 4-bit up/down counter.
module tb_counter_seq_ctrl;
  logic       clk = 1'b0;
  logic       mr = 1'b1;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] preset = 4'd0;
  logic [7:0] steps = 8'd0;
  logic [3:0] fault = 4'd0;
  logic       sel = 1'b0;

  logic       busy1, done1, mis1, busy3, done3, mis3;
  logic [3:0] wraps1, wraps3;
  logic [3:0] cnt1_q, cnt3_q;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  counter_seq_ctrl_if bus1();
  counter_seq_ctrl_if bus3();

  counter_seq_ctrl #(.DIV(1), .STEP_W(8)) u_dut1 (
    .clk(clk), .mr(mr), .start(start1), .mode(mode), .preset(preset), .steps(steps),
    .cbus(bus1), .busy(busy1), .done(done1), .wraps(wraps1), .mismatch(mis1)
  );

  counter_seq_ctrl #(.DIV(3), .STEP_W(8)) u_dut3 (
    .clk(clk), .mr(mr), .start(start3), .mode(mode), .preset(preset), .steps(steps),
    .cbus(bus3), .busy(busy3), .done(done3), .wraps(wraps3), .mismatch(mis3)
  );

  // External counters: co is the combinational terminal count for the current direction
  always_ff @(posedge clk or posedge mr) begin
    if (mr) cnt1_q <= 4'd0;
    else if (bus1.load) cnt1_q <= bus1.d;
    else if (bus1.en) cnt1_q <= bus1.dn ? cnt1_q - 4'd1 : cnt1_q + 4'd1;
  end
  always_ff @(posedge clk or posedge mr) begin
    if (mr) cnt3_q <= 4'd0;
    else if (bus3.load) cnt3_q <= bus3.d;
    else if (bus3.en) cnt3_q <= bus3.dn ? cnt3_q - 4'd1 : cnt3_q + 4'd1;
  end
  assign bus1.q_in  = cnt1_q + fault;
  assign bus1.co_in = bus1.dn ? (cnt1_q == 4'h0) : (cnt1_q == 4'hF);
  assign bus3.q_in  = cnt3_q;
  assign bus3.co_in = bus3.dn ? (cnt3_q == 4'h0) : (cnt3_q == 4'hF);

  logic       en_s, load_s, busy_s, done_s, dn_s, mis_s;
  logic [3:0] q_s, d_s, wraps_s;
  always_comb begin
    en_s    = sel ? bus3.en   : bus1.en;
    load_s  = sel ? bus3.load : bus1.load;
    busy_s  = sel ? busy3     : busy1;
    done_s  = sel ? done3     : done1;
    dn_s    = sel ? bus3.dn   : bus1.dn;
    mis_s   = sel ? mis3      : mis1;
    q_s     = sel ? cnt3_q    : cnt1_q;
    d_s     = sel ? bus3.d    : bus1.d;
    wraps_s = sel ? wraps3    : wraps1;
  end

  task automatic chk(input string tag, input bit ok);
    n_chk++;
    if (ok) n_pass++;
    else $error("FAIL %s", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n_en, n_load, n_busy, first_en, last_en;
  bit got_done;

  // Issue a start, then observe until done (bounded). Stops on the done cycle.
  task automatic run_cmd(input bit s, input logic m, input logic [3:0] p,
                         input logic [7:0] n, input int start_len, input int fault_at);
    sel = s; mode = m; preset = p; steps = n;
    if (s) start3 = 1'b1; else start1 = 1'b1;
    step();
    n_en = 0; n_load = 0; n_busy = 0; first_en = -1; last_en = -1; got_done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i + 1 >= start_len) begin start1 = 1'b0; start3 = 1'b0; end
      if (busy_s) n_busy++;
      if (load_s) n_load++;
      if (en_s) begin
        if (first_en < 0) first_en = i;
        last_en = i;
        n_en++;
        if (n_en == fault_at) fault = 4'd1;
      end
      if (done_s) begin got_done = 1'b1; break; end
      step();
    end
    start1 = 1'b0; start3 = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nd;
    // Reset state (asynchronous, before any clock edge)
    #2;
    chk("rst_load", bus1.load === 1'b0);
    chk("rst_en", bus1.en === 1'b0);
    chk("rst_dn", bus1.dn === 1'b0);
    chk("rst_d", bus1.d === 4'h0);
    chk("rst_busy", busy1 === 1'b0);
    chk("rst_done", done1 === 1'b0);
    chk("rst_wraps", wraps1 === 4'h0);
    chk("rst_mis", mis1 === 1'b0);
    repeat (2) step();
    mr = 1'b0;
    step();

    // Up run, DIV=1
    run_cmd(1'b0, 1'b0, 4'hD, 8'd5, 1, 0);
    chk("up_done", got_done === 1'b1);
    chk("up_en", n_en === 5);
    chk("up_load", n_load === 1);
    chk("up_busy", n_busy === 7);
    chk("up_first_en", first_en === 1);
    chk("up_last_en", last_en === 5);
    chk("up_q", q_s === 4'h2);
    chk("up_wraps", wraps_s === 4'd1);
    chk("up_dn", dn_s === 1'b0);
    chk("up_mis", mis_s === 1'b0);
    chk("up_done_busy", busy_s === 1'b0);
    step();
    chk("up_done_pulse", done_s === 1'b0);
    chk("up_wraps_hold", wraps_s === 4'd1);
    chk("up_d_hold", d_s === 4'hD);

    // Zero steps on DIV=3 instance; start held into LOAD must be ignored
    run_cmd(1'b1, 1'b0, 4'h7, 8'd0, 2, 0);
    chk("zero_done", got_done === 1'b1);
    chk("zero_en", n_en === 0);
    chk("zero_busy", n_busy === 2);
    chk("zero_q", q_s === 4'h7);
    chk("zero_wraps", wraps_s === 4'd0);
    step();
    chk("zero_idle", busy_s === 1'b0);

    // Down run, DIV=3
    run_cmd(1'b1, 1'b1, 4'h1, 8'd4, 1, 0);
    chk("dn_done", got_done === 1'b1);
    chk("dn_en", n_en === 4);
    chk("dn_busy", n_busy === 12);
    chk("dn_first_en", first_en === 1);
    chk("dn_last_en", last_en === 10);
    chk("dn_q", q_s === 4'hD);
    chk("dn_wraps", wraps_s === 4'd1);
    step();
    chk("dn_dn_hold", dn_s === 1'b1);
    chk("dn_d_hold", d_s === 4'h1);

    // Saturation, DIV=1
    run_cmd(1'b0, 1'b0, 4'h0, 8'd255, 1, 0);
    chk("sat_done", got_done === 1'b1);
    chk("sat_en", n_en === 255);
    chk("sat_busy", n_busy === 257);
    chk("sat_wraps", wraps_s === 4'hF);
    chk("sat_q", q_s === 4'hF);
    step();

    // Reset mid-run after the 3rd en of 10
    sel = 1'b0; mode = 1'b1; preset = 4'h5; steps = 8'd10; start1 = 1'b1;
    step();
    start1 = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (en_s) nd++;
      if (nd == 3) break;
      step();
    end
    chk("mid_en_seen", nd === 3);
    #2 mr = 1'b1;
    #1;
    chk("mid_busy", busy1 === 1'b0);
    chk("mid_en", bus1.en === 1'b0);
    chk("mid_load", bus1.load === 1'b0);
    chk("mid_d", bus1.d === 4'h0);
    chk("mid_dn", bus1.dn === 1'b0);
    nd = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done1) nd++;
    end
    mr = 1'b0;
    step();
    if (done1) nd++;
    chk("mid_no_done", nd === 0);
    chk("mid_idle", busy1 === 1'b0);
    run_cmd(1'b0, 1'b0, 4'h3, 8'd2, 1, 0);
    chk("post_done", got_done === 1'b1);
    chk("post_en", n_en === 2);
    chk("post_busy", n_busy === 4);
    chk("post_q", q_s === 4'h5);
    chk("post_wraps", wraps_s === 4'd0);
    step();

    // q_in disturbed after the 2nd en
    run_cmd(1'b0, 1'b0, 4'h8, 8'd4, 1, 2);
    chk("chk_done", got_done === 1'b1);
`ifdef CTRL_CHECK_EN
    chk("chk_mis", mis1 === 1'b1);
    step();
    chk("chk_mis_hold", mis1 === 1'b1);
`else
    chk("chk_mis", mis1 === 1'b0);
    step();
    chk("chk_mis_hold", mis1 === 1'b0);
`endif
    fault = 4'd0;
    mode = 1'b0; preset = 4'h1; steps = 8'd1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("chk_clear", mis1 === 1'b0);
    repeat (5) step();
    chk("chk_clean_mis", mis1 === 1'b0);
    chk("chk_clean_q", cnt1_q === 4'h2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Command-side driver for the team's 4-bit synchronous up/down counter (mr/load/en/dn/d in, q/co out). It takes a single start request and runs the counter: it loads a preset, then issues a programmed number of count-enable pulses in a chosen direction at a divided rate. It counts carry/borrow events seen on co and reports completion. With the optional check enabled, it also verifies q against an internal reference model.

Parameters:
DIV, 4, enable-pulse spacing in clk cycles (1 = en every cycle, range 1..255)
STEP_W, 8, width of the step-count input

Ports:
clk  input  1  system clock, rising edge
mr  input  1  asynchronous active-high reset
start  input  1  one-cycle request, sampled in IDLE only
mode  input  1  0 = count up, 1 = count down
preset  input  4  value to load into the counter
steps  input  STEP_W  number of en pulses to issue
q_in  input  4  counter q output
co_in  input  1  counter co output
load  output  1  to counter load
en  output  1  to counter en
dn  output  1  to counter dn
d  output  4  to counter d
busy  output  1  high from LOAD through DRAIN
done  output  1  one-cycle completion pulse
wraps  output  4  number of co_in 0->1 transitions during the run, saturating at 15
mismatch  output  1  sticky model-compare error

Behaviour:
- Reset (mr=1, async): state=IDLE; load=en=dn=done=mismatch=0; busy=0; d=0; wraps=0; prescaler and step counter=0. Reset mid-run aborts immediately; no done pulse is issued.
- IDLE: on start=1, latch preset, steps and mode; clear wraps and mismatch; go to LOAD. start is ignored in all other states.
- LOAD (1 cycle): load=1, d=latched preset, en=0, busy=1; reference model exp <- preset. Next state is RUN if steps!=0, else DRAIN.
- RUN:
  - en=1 for exactly one cycle every DIV cycles. The first en occurs on the first RUN cycle.
  - dn is held at the latched mode for the whole run.
  - Each en decrements the remaining-step count and updates exp <- exp+1 (up) or exp-1 (down), mod 16.
  - When the final en is issued, go to DRAIN. Exactly `steps` en pulses are issued.
- DRAIN (1 cycle): load=en=0. Lets the counter register the final update.
- DONE: done=1 for one cycle, busy=0; return to IDLE. A start in this cycle is ignored; start is accepted from the following IDLE cycle.
- dn and d remain at their latched values until the next start is accepted.
- Wrap counting: co_in is registered each cycle. wraps increments when co_in=1 and its previous sample=0, in any busy state. It saturates at 15, never wraps, and holds its value after done until the next start.
- Width rules: exp is 4-bit modulo arithmetic. The step counter is STEP_W bits. steps = 2^STEP_W-1 must run correctly. The prescaler counts 0..DIV-1.
- DIV=1 gives back-to-back en pulses; the step count is unchanged.

Optional Feature:
CTRL_CHECK_EN
- Defined: in the cycle after each load or en pulse, compare q_in with exp. On inequality, set mismatch=1 (sticky until the next accepted start or reset).
- Not defined: no reference model is built; mismatch is tied to 0.

Test Plan:
- Up run: preset=4'hD, mode=0, steps=5, DIV=1 -> load for 1 cycle, then 5 consecutive en pulses, dn=0. Counter q goes D,E,F,0,1,2; wraps=1; done 1 cycle after DRAIN; mismatch=0.
- Down run with divider: DIV=3, preset=4'h1, mode=1, steps=4 -> en pulses 3 cycles apart. q goes 1,0,F,E,D; wraps=1; busy high for LOAD + 10 + DRAIN cycles.
- Zero steps: steps=0, preset=4'h7 -> LOAD, DRAIN, DONE; no en pulse; q=7; wraps=0.
- Saturation: preset=0, mode=0, steps=255, DIV=1 -> 255 en pulses; wraps=15 (saturated); final q=4'hF.
- Reset mid-run: assert mr during RUN at step 3 of 10 -> all outputs 0 asynchronously; no done pulse. A new start after mr falls runs normally.
- Check (CTRL_CHECK_EN defined): force q_in off by one after the 2nd en -> mismatch=1 from the next cycle and held through done. mismatch clears on the next start.
